// File: rtl/alu_pkg.sv
// Shared control-word bit positions and op-codes for the ALU control/datapath pair.
package alu_pkg;

    localparam int C_LD_M  = 0;
    localparam int C_LD_Q  = 1;
    localparam int C_ADD   = 2;
    localparam int C_SUB   = 3;
    localparam int C_SHL   = 4;
    localparam int C_CNT   = 5;
    localparam int C_OUT_A = 6;
    localparam int C_OUT_Q = 7;
    localparam int C_CLR   = 8;
    localparam int C_ASR   = 9;
    localparam int C_TO_Q  = 10;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Multiply and divide run WIDTH counted iterations; add/sub are single-step.
    function automatic logic op_iterates(input logic [1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB: r = 1'b0;
            OP_MUL, OP_DIV: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_datapath_add_sub.sv
// Combinational WIDTH-bit adder/subtractor with signed-overflow flag.
module add_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b;

    assign w_b   = i_b ^ {WIDTH{i_sub}};
    assign o_sum = i_a + w_b + {{(WIDTH-1){1'b0}}, i_sub};
    // Overflow when both addend signs agree but the result sign differs.
    assign o_ovf = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_datapath.sv
// A/Q/M register datapath executing one micro-operation per clock from the
// 11-bit control word; returns the Booth/divide status flags to the control unit.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inbus,
    input  logic [10:0]      c,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             q_zero,
    output logic             q_minus_one,
    output logic             a_seven,
    output logic             cnt_7,
    output logic             overflow
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_q1;
    logic             r_qbit;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_outbus;
    logic             r_out_valid;
    logic             r_ovf;

    logic [WIDTH-1:0] w_l;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_a_add;
    logic             w_a_adder_wr;
    logic             w_q_adder_wr;

    assign w_l     = c[C_TO_Q] ? r_q : r_a;
    assign w_a_add = (c[C_ADD] | c[C_SUB]) & ~c[C_TO_Q];

    // Overflow only tracks adder results that actually land in a register.
    assign w_a_adder_wr = w_a_add & ~c[C_LD_Q] & ~c[C_CLR];
    assign w_q_adder_wr = c[C_TO_Q] & ~c[C_LD_Q];

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .i_a   (w_l),
        .i_b   (r_m),
        .i_sub (c[C_SUB]),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_q1        <= 1'b0;
            r_qbit      <= 1'b0;
            r_cnt       <= '0;
            r_outbus    <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (c[C_LD_M])
                r_m <= inbus;

            if (c[C_LD_Q] || c[C_CLR])
                r_a <= '0;
            else if (w_a_add)
                r_a <= w_sum;
            else if (c[C_SHL])
                r_a <= {r_a[WIDTH-2:0], r_q[WIDTH-1]};
            else if (c[C_ASR])
                r_a <= {r_a[WIDTH-1], r_a[WIDTH-1:1]};

            if (c[C_LD_Q])
                r_q <= inbus;
            else if (c[C_TO_Q])
                r_q <= w_sum;
            else if (c[C_SHL])
                r_q <= {r_q[WIDTH-2:0], r_qbit};
            else if (c[C_ASR])
                r_q <= {r_a[0], r_q[WIDTH-1:1]};

            if (c[C_CLR])
                r_q1 <= 1'b0;
            else if (c[C_ASR])
                r_q1 <= r_q[0];

            // Restoring divide: a non-negative trial difference yields quotient bit 1.
            if (c[C_SUB] && !c[C_TO_Q])
                r_qbit <= ~w_sum[WIDTH-1];

            if (c[C_LD_Q])
                r_cnt <= '0;
            else if (c[C_CNT])
                r_cnt <= r_cnt + CNT_W'(1);

            if (c[C_OUT_Q])
                r_outbus <= r_q;
            else if (c[C_OUT_A])
                r_outbus <= r_a;
            r_out_valid <= c[C_OUT_A] | c[C_OUT_Q];

            if (w_a_adder_wr || w_q_adder_wr)
                r_ovf <= w_ovf;
        end
    end

    assign outbus      = r_outbus;
    assign out_valid   = r_out_valid;
    assign q_zero      = r_q[0];
    assign q_minus_one = r_q1;
    assign a_seven     = r_a[WIDTH-1];
    assign cnt_7       = (r_cnt == CNT_W'(WIDTH-1));
    assign overflow    = r_ovf;

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Register-and-adder datapath driven by the 11-bit control word from the ALU control unit. It executes 8-bit add, subtract, Booth multiply and restoring divide one micro-operation per clock. It returns the status flags the control unit sequences on: Q[0], Q[-1], A[7] and counter-at-terminal. It is the execution end of the `c[10:0]` / status-flag interface, and it also owns operand loading from `inbus` and result unloading to `outbus`.

## Interface
- `WIDTH`, default 8: operand width of A, Q and M.
- `CNT_W`, default `$clog2(WIDTH)`: width of the iteration counter.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `inbus`, input, WIDTH: operand bus, sampled on `c[0]` and `c[1]`.
- `c`, input, 11: one-hot-or-combined micro-operation strobes from the control unit.
- `outbus`, output, WIDTH: registered result bus.
- `out_valid`, output, 1: high for exactly one cycle when `outbus` was loaded on the previous edge.
- `q_zero`, output, 1: equals Q[0].
- `q_minus_one`, output, 1: equals the Q[-1] register.
- `a_seven`, output, 1: equals A[WIDTH-1].
- `cnt_7`, output, 1: high when `cnt == WIDTH-1`.
- `overflow`, output, 1: signed overflow of the last adder write.

## Operation
- Registers: A, Q, M (WIDTH each), Q_1, qbit, cnt (CNT_W), outbus, out_valid, overflow.
- Adder: `sum = L + (M ^ {WIDTH{c[3]}}) + c[3]`.
  - L is Q when `c[10]` is high, otherwise A.
  - Overflow is signed overflow of that sum.
- Control bits:
  - `c[0]`: M <= inbus.
  - `c[1]`: Q <= inbus, A <= 0, cnt <= 0.
  - `c[8]`: A <= 0, Q_1 <= 0.
  - `c[2]` or `c[3]` with `c[10]` low: A <= sum.
    - If `c[3]` is high, also qbit <= ~sum[WIDTH-1].
  - `c[10]`: Q <= sum.
  - `c[4]`: {A,Q} <= {A[WIDTH-2:0], Q, qbit}. This is a left shift that inserts the quotient bit.
  - `c[9]`: {A,Q,Q_1} <= arithmetic right shift by 1. A[WIDTH-1] is replicated.
  - `c[5]`: cnt <= cnt + 1, wrapping at 2^CNT_W.
  - `c[6]`: outbus <= A.
  - `c[7]`: outbus <= Q. If `c[6]` is also high, `c[7]` wins.
  - `overflow` updates only on edges where an adder write (A or Q) occurs.
- Per-register write priority when strobes collide:
  - A: `c[1]` > `c[8]` > adder > `c[4]` > `c[9]`.
  - Q: `c[1]` > `c[10]` > `c[4]` > `c[9]`.
  - Q_1: `c[8]` > `c[9]`.
- `c` all-zero means every register holds.
- Unused combinations of `c` need not give meaningful arithmetic results, but must follow the priority rules above.

## Timing
- Every strobe takes effect on the `clk` rising edge where it is sampled high. Registers update one edge after the strobe.
- Status outputs are combinational from registers. They reflect an operation in the cycle after its edge.
- `out_valid` is registered: it goes high in the cycle after `c[6]` or `c[7]` is sampled.
- `rst` clears all registers and outputs to 0 immediately and asynchronously: `outbus=0`, `out_valid=0`, `overflow=0`, `q_zero=0`, `q_minus_one=0`, `a_seven=0`, `cnt_7=0`.
- Reset during an operation discards all partial state. There is no recovery handshake; the control unit restarts from `start`.
- Counter wrap: at `cnt == WIDTH-1`, `c[5]` yields 0 and `cnt_7` falls.

## Structure
- Shared package `alu_pkg` holds:
  - The control-bit index localparams: `C_LD_M=0`, `C_LD_Q=1`, `C_ADD=2`, `C_SUB=3`, `C_SHL=4`, `C_CNT=5`, `C_OUT_A=6`, `C_OUT_Q=7`, `C_CLR=8`, `C_ASR=9`, `C_TO_Q=10`.
  - The op-code localparams: `OP_ADD=0`, `OP_SUB=1`, `OP_MUL=2`, `OP_DIV=3`.
- One sub-module: `add_sub`, the combinational WIDTH-bit adder/subtractor with signed-overflow output.

## Test plan
- **Add:** `c[0]` with inbus=25, then `c[1]` with inbus=17, then `c[10]`, then `c[7]` -> outbus=42, out_valid high for one cycle, overflow=0.
- **Subtract with overflow:** M=1, Q=0x80, then `c[3]|c[10]` -> Q=0x7F, overflow=1. Then `c[3]|c[10]` with M=9, Q=5 -> Q=0xFC, overflow=0.
- **Booth multiply:** M=5, Q=0xFD (-3), `c[8]`, then 8 directed iterations (adder per {q_zero,q_minus_one}, then `c[9]|c[5]`) -> {A,Q}=0xFFF1, cnt=0 after the wrap.
- **Divide step:** A=0, Q=0x80, M=1.
  - `c[2]|c[3]` -> A=0xFF, qbit=0, a_seven=1.
  - `c[2]` -> A=0x00.
  - `c[4]` -> A=0x01, Q=0x00.
- **Priority:** `c[1]|c[2]|c[9]` with inbus=0x33 -> A=0, Q=0x33, cnt=0. Simultaneous `c[6]|c[7]` -> outbus=Q.
- **Async reset:** assert `rst` mid-multiply, between clock edges -> all outputs 0 before the next edge. They stay 0 until the first strobe after release.
